// File: rtl/game_pkg.sv
// Shared game definitions: screen/state encoding and the millisecond base
// used by every timer in the match controller.
package game_pkg;

  typedef enum logic [2:0] {
    ST_START     = 3'd0,
    ST_WAIT_PEER = 3'd1,
    ST_SHOOT     = 3'd2,
    ST_KEEP      = 3'd3,
    ST_WIN       = 3'd4,
    ST_LOSE      = 3'd5,
    ST_DRAW      = 3'd6
  } state_t;

  localparam int MS_PER_SEC = 1000;

endpackage

// File: rtl/ms_timer.sv
// Millisecond timer: a CLK_HZ/1000 tick divider feeding a loadable ms
// down-counter. 'expired' pulses in the cycle the count reaches zero.
module ms_timer
  import game_pkg::*;
#(
  parameter int CLK_HZ = 65_000_000,
  parameter int MS_W   = 12
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [MS_W-1:0] load_ms,
  output logic            expired
);

  localparam int DIV   = CLK_HZ / MS_PER_SEC;
  localparam int DIV_W = $clog2(DIV + 1);

  logic [DIV_W-1:0] div_q;
  logic [MS_W-1:0]  ms_q;
  logic             tick;

  assign tick    = (div_q == DIV_W'(DIV - 1));
  assign expired = tick && (ms_q == MS_W'(1));

  // Loading with zero leaves the timer idle; it never expires from zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_q <= '0;
      ms_q  <= '0;
    end else if (start) begin
      div_q <= '0;
      ms_q  <= load_ms;
    end else begin
      div_q <= tick ? '0 : div_q + DIV_W'(1);
      if (tick && (ms_q != '0)) begin
        ms_q <= ms_q - MS_W'(1);
      end
    end
  end

endmodule

// File: rtl/match_state_ctl.sv
// Penalty shoot-out match controller: start/handshake, alternating turns with
// timeouts, scoring, early decision, sudden death and result screens.
module match_state_ctl
  import game_pkg::*;
#(
  parameter int ROUNDS          = 5,
  parameter int MAX_ROUNDS      = 10,
  parameter int SCORE_W         = 4,
  parameter int CLK_HZ          = 65_000_000,
  parameter int SHOT_TIMEOUT_MS = 3000,
  parameter int PEER_TIMEOUT_MS = 1000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               solo_enable,
  input  logic               left_clicked,
  input  logic               connect_ok,
  input  logic               shot_valid,
  input  logic               shot_goal,
  output logic [2:0]         game_state,
  output logic               shot_window,
  output logic [SCORE_W-1:0] score_player,
  output logic [SCORE_W-1:0] score_opp,
  output logic [SCORE_W-1:0] round_idx,
  output logic               match_done
);

  localparam int MAX_MS = (SHOT_TIMEOUT_MS > PEER_TIMEOUT_MS) ? SHOT_TIMEOUT_MS : PEER_TIMEOUT_MS;
  localparam int MS_W   = $clog2(MAX_MS + 1);
  localparam logic [SCORE_W-1:0] ROUNDS_L = SCORE_W'(ROUNDS);
  localparam logic [SCORE_W-1:0] MAX_L    = SCORE_W'(MAX_ROUNDS);

  state_t             state_q, state_d;
  logic [SCORE_W-1:0] scorePlayer_q, scorePlayer_d;
  logic [SCORE_W-1:0] scoreOpp_q, scoreOpp_d;
  logic [SCORE_W-1:0] round_q, round_d;
  logic               solo_q, solo_d;
  logic               clickPrev_q, clickPulse_q;
  logic               connPrev_q;
  logic               shotWindow_q, matchDone_q;

  logic               connFall;
  logic               timerStart, timerExpired;
  logic [MS_W-1:0]    timerLoad;
  logic [SCORE_W-1:0] oppNew, roundNew, diff;

  function automatic logic [SCORE_W-1:0] satInc(input logic [SCORE_W-1:0] v);
    return (&v) ? v : v + SCORE_W'(1);
  endfunction

  assign connFall = connPrev_q && !connect_ok;

  // Every state change reloads the timer; untimed states load zero (idle).
  assign timerStart = (state_d != state_q);
  always_comb begin
    timerLoad = '0;
    if (state_d == ST_WAIT_PEER) begin
      timerLoad = MS_W'(PEER_TIMEOUT_MS);
    end else if ((state_d == ST_SHOOT) || (state_d == ST_KEEP)) begin
      timerLoad = MS_W'(SHOT_TIMEOUT_MS);
    end
  end

  ms_timer #(
    .CLK_HZ (CLK_HZ),
    .MS_W   (MS_W)
  ) u_timer (
    .clk     (clk),
    .rst     (rst),
    .start   (timerStart),
    .load_ms (timerLoad),
    .expired (timerExpired)
  );

  always_comb begin
    state_d       = state_q;
    scorePlayer_d = scorePlayer_q;
    scoreOpp_d    = scoreOpp_q;
    round_d       = round_q;
    solo_d        = solo_q;
    oppNew        = (shot_valid && shot_goal) ? satInc(scoreOpp_q) : scoreOpp_q;
    roundNew      = round_q + SCORE_W'(1);
    diff          = (scorePlayer_q >= oppNew) ? scorePlayer_q - oppNew : oppNew - scorePlayer_q;

    case (state_q)
      ST_START: begin
        if (clickPulse_q) begin
          solo_d        = solo_enable;
          state_d       = solo_enable ? ST_SHOOT : ST_WAIT_PEER;
          scorePlayer_d = '0;
          scoreOpp_d    = '0;
          round_d       = '0;
        end
      end
      ST_WAIT_PEER: begin
        if (connect_ok) begin
          state_d = ST_SHOOT;
        end else if (timerExpired) begin
          state_d = ST_START;
        end
      end
      ST_SHOOT: begin
        if (!solo_q && connFall) begin
          state_d       = ST_START;
          scorePlayer_d = '0;
          scoreOpp_d    = '0;
          round_d       = '0;
        end else if (shot_valid) begin
          if (shot_goal) begin
            scorePlayer_d = satInc(scorePlayer_q);
          end
          state_d = ST_KEEP;
        end else if (timerExpired) begin
          state_d = ST_KEEP;
        end
      end
      ST_KEEP: begin
        if (!solo_q && connFall) begin
          state_d       = ST_START;
          scorePlayer_d = '0;
          scoreOpp_d    = '0;
          round_d       = '0;
        end else if (shot_valid || timerExpired) begin
          // The end condition is judged on the scores including this save/goal.
          scoreOpp_d = oppNew;
          round_d    = roundNew;
          if (((roundNew < ROUNDS_L) && (diff > (ROUNDS_L - roundNew))) ||
              ((roundNew >= ROUNDS_L) && (diff != '0))) begin
            state_d = (scorePlayer_q > oppNew) ? ST_WIN : ST_LOSE;
          end else if ((roundNew == MAX_L) && (diff == '0)) begin
            state_d = ST_DRAW;
          end else begin
            state_d = ST_SHOOT;
          end
        end
      end
      ST_WIN, ST_LOSE, ST_DRAW: begin
        if (clickPulse_q) begin
          state_d       = ST_START;
          scorePlayer_d = '0;
          scoreOpp_d    = '0;
          round_d       = '0;
        end
      end
      default: state_d = ST_START;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_START;
      scorePlayer_q <= '0;
      scoreOpp_q    <= '0;
      round_q       <= '0;
      solo_q        <= 1'b0;
      clickPrev_q   <= 1'b0;
      clickPulse_q  <= 1'b0;
      connPrev_q    <= 1'b0;
      shotWindow_q  <= 1'b0;
      matchDone_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      scorePlayer_q <= scorePlayer_d;
      scoreOpp_q    <= scoreOpp_d;
      round_q       <= round_d;
      solo_q        <= solo_d;
      clickPrev_q   <= left_clicked;
      clickPulse_q  <= left_clicked && !clickPrev_q;
      connPrev_q    <= connect_ok;
      shotWindow_q  <= (state_d == ST_SHOOT) || (state_d == ST_KEEP);
      matchDone_q   <= (state_d == ST_WIN) || (state_d == ST_LOSE) || (state_d == ST_DRAW);
    end
  end

  assign game_state   = state_q;
  assign shot_window  = shotWindow_q;
  assign score_player = scorePlayer_q;
  assign score_opp    = scoreOpp_q;
  assign round_idx    = round_q;
  assign match_done   = matchDone_q;

endmodule

// File: tb/tb_match_state_ctl.sv
// Directed bench for match_state_ctl: a vector table for the solo, early
// decision and peer paths, plus hand sequences for sudden death, draw, timeouts and reset.
module tb_match_state_ctl;

  localparam logic [2:0] S_START = 3'd0, S_WAIT = 3'd1, S_SHOOT = 3'd2, S_KEEP = 3'd3,
                         S_WIN = 3'd4, S_LOSE = 3'd5, S_DRAW = 3'd6;

  logic       clk = 1'b0;
  logic       rst, solo_enable, left_clicked, connect_ok, shot_valid, shot_goal;
  logic [2:0] game_state;
  logic       shot_window, match_done;
  logic [3:0] score_player, score_opp, round_idx;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       solo, click, conn, valid, goal;
    logic [2:0] st;
    logic       win;
    logic [3:0] sp, so, rd;
    logic       done;
  } vec_t;

  vec_t vecs[$];

  always #5 clk = ~clk;

  match_state_ctl #(
    .ROUNDS          (5),
    .MAX_ROUNDS      (7),
    .SCORE_W         (4),
    .CLK_HZ          (1000),
    .SHOT_TIMEOUT_MS (8),
    .PEER_TIMEOUT_MS (4)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .solo_enable  (solo_enable),
    .left_clicked (left_clicked),
    .connect_ok   (connect_ok),
    .shot_valid   (shot_valid),
    .shot_goal    (shot_goal),
    .game_state   (game_state),
    .shot_window  (shot_window),
    .score_player (score_player),
    .score_opp    (score_opp),
    .round_idx    (round_idx),
    .match_done   (match_done)
  );

  task automatic applyStimulus(input logic solo, input logic click, input logic conn,
                               input logic valid, input logic goal);
    solo_enable  = solo;
    left_clicked = click;
    connect_ok   = conn;
    shot_valid   = valid;
    shot_goal    = goal;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [2:0] st, input logic win,
                             input logic [3:0] sp, input logic [3:0] so, input logic [3:0] rd,
                             input logic done);
    checks++;
    if ({game_state, shot_window, score_player, score_opp, round_idx, match_done} !==
        {st, win, sp, so, rd, done}) begin
      errors++;
      $display("[TB] FAIL %s: got st=%0d win=%0b sp=%0d so=%0d rd=%0d done=%0b, expected st=%0d win=%0b sp=%0d so=%0d rd=%0d done=%0b",
               name, game_state, shot_window, score_player, score_opp, round_idx, match_done,
               st, win, sp, so, rd, done);
    end
  endtask

  task automatic addVec(input logic solo, input logic click, input logic conn, input logic valid,
                        input logic goal, input logic [2:0] st, input logic win, input logic [3:0] sp,
                        input logic [3:0] so, input logic [3:0] rd, input logic done);
    vec_t v;
    v.solo = solo; v.click = click; v.conn = conn; v.valid = valid; v.goal = goal;
    v.st = st; v.win = win; v.sp = sp; v.so = so; v.rd = rd; v.done = done;
    vecs.push_back(v);
  endtask

  initial begin
    // solo path and early decision
    addVec(1, 1, 0, 0, 0, S_START, 0, 0, 0, 0, 0);
    addVec(1, 0, 0, 0, 0, S_SHOOT, 1, 0, 0, 0, 0);
    addVec(1, 0, 0, 1, 1, S_KEEP,  1, 1, 0, 0, 0);
    addVec(1, 0, 0, 1, 0, S_SHOOT, 1, 1, 0, 1, 0);
    addVec(1, 0, 0, 0, 0, S_SHOOT, 1, 1, 0, 1, 0);
    addVec(1, 0, 0, 1, 1, S_KEEP,  1, 2, 0, 1, 0);
    addVec(1, 0, 0, 1, 0, S_SHOOT, 1, 2, 0, 2, 0);
    addVec(1, 0, 0, 1, 1, S_KEEP,  1, 3, 0, 2, 0);
    addVec(1, 0, 0, 1, 0, S_WIN,   0, 3, 0, 3, 1);
    addVec(1, 0, 0, 1, 1, S_WIN,   0, 3, 0, 3, 1);
    addVec(1, 1, 0, 0, 0, S_WIN,   0, 3, 0, 3, 1);
    addVec(1, 0, 0, 0, 0, S_START, 0, 0, 0, 0, 0);
    // peer handshake timeout, then successful handshake and abort in KEEP
    addVec(0, 1, 0, 0, 0, S_START, 0, 0, 0, 0, 0);
    addVec(0, 0, 0, 0, 0, S_WAIT,  0, 0, 0, 0, 0);
    addVec(0, 0, 0, 0, 0, S_WAIT,  0, 0, 0, 0, 0);
    addVec(0, 0, 0, 0, 0, S_WAIT,  0, 0, 0, 0, 0);
    addVec(0, 0, 0, 0, 0, S_WAIT,  0, 0, 0, 0, 0);
    addVec(0, 0, 0, 0, 0, S_START, 0, 0, 0, 0, 0);
    addVec(0, 1, 0, 0, 0, S_START, 0, 0, 0, 0, 0);
    addVec(0, 0, 0, 0, 0, S_WAIT,  0, 0, 0, 0, 0);
    addVec(0, 0, 0, 0, 0, S_WAIT,  0, 0, 0, 0, 0);
    addVec(0, 0, 1, 0, 0, S_SHOOT, 1, 0, 0, 0, 0);
    addVec(0, 0, 1, 1, 1, S_KEEP,  1, 1, 0, 0, 0);
    addVec(0, 0, 0, 0, 0, S_START, 0, 0, 0, 0, 0);

    rst = 1'b1;
    solo_enable = 1'b1; left_clicked = 1'b0; connect_ok = 1'b0; shot_valid = 1'b0; shot_goal = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset", S_START, 0, 0, 0, 0, 0);
    rst = 1'b0;

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].solo, vecs[i].click, vecs[i].conn, vecs[i].valid, vecs[i].goal);
      checkOutput($sformatf("vec%0d", i), vecs[i].st, vecs[i].win, vecs[i].sp, vecs[i].so,
                  vecs[i].rd, vecs[i].done);
    end

    // sudden death: 5 pairs of goals, then player misses and opponent scores
    applyStimulus(1, 1, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0);
    checkOutput("sd_start", S_SHOOT, 1, 0, 0, 0, 0);
    for (int i = 1; i <= 5; i++) begin
      applyStimulus(1, 0, 0, 1, 1);
      checkOutput($sformatf("sd_shoot%0d", i), S_KEEP, 1, 4'(i), 4'(i - 1), 4'(i - 1), 0);
      applyStimulus(1, 0, 0, 1, 1);
      checkOutput($sformatf("sd_keep%0d", i), S_SHOOT, 1, 4'(i), 4'(i), 4'(i), 0);
    end
    applyStimulus(1, 0, 0, 1, 0);
    checkOutput("sd_miss", S_KEEP, 1, 5, 5, 5, 0);
    applyStimulus(1, 0, 0, 1, 1);
    checkOutput("sd_lose", S_LOSE, 0, 5, 6, 6, 1);

    // draw after MAX_ROUNDS level pairs
    applyStimulus(1, 1, 0, 0, 0);
    checkOutput("lose_hold", S_LOSE, 0, 5, 6, 6, 1);
    applyStimulus(1, 0, 0, 0, 0);
    checkOutput("lose_exit", S_START, 0, 0, 0, 0, 0);
    applyStimulus(1, 1, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0);
    for (int i = 1; i <= 7; i++) begin
      applyStimulus(1, 0, 0, 1, 1);
      applyStimulus(1, 0, 0, 1, 1);
      if (i == 7) checkOutput("draw", S_DRAW, 0, 7, 7, 7, 1);
      else checkOutput($sformatf("draw_pair%0d", i), S_SHOOT, 1, 4'(i), 4'(i), 4'(i), 0);
    end

    // shot_valid in the expiry cycle wins, then a KEEP timeout counts as a save
    applyStimulus(1, 1, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0);
    checkOutput("draw_exit", S_START, 0, 0, 0, 0, 0);
    applyStimulus(1, 1, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0);
    repeat (7) applyStimulus(1, 0, 0, 0, 0);
    checkOutput("to_pre", S_SHOOT, 1, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 1, 1);
    checkOutput("to_valid_wins", S_KEEP, 1, 1, 0, 0, 0);
    repeat (7) applyStimulus(1, 0, 0, 0, 0);
    checkOutput("keep_pre", S_KEEP, 1, 1, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0);
    checkOutput("keep_timeout", S_SHOOT, 1, 1, 0, 1, 0);

    // reset mid-SHOOT
    applyStimulus(1, 0, 0, 0, 0);
    rst = 1'b1;
    applyStimulus(1, 0, 0, 0, 0);
    checkOutput("rst_mid", S_START, 0, 0, 0, 0, 0);
    rst = 1'b0;
    applyStimulus(1, 0, 0, 0, 0);
    checkOutput("rst_after", S_START, 0, 0, 0, 0, 0);

    // plain SHOOT timeout counts as a miss
    applyStimulus(1, 1, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0);
    repeat (8) applyStimulus(1, 0, 0, 0, 0);
    checkOutput("shoot_timeout", S_KEEP, 1, 0, 0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
